kv_arbiter: RTL and testbench

Two-master Wishbone arbiter that shares the single `keyvalue` store between the management-SoC Wishbone bus (master 0) and a logic-analyzer-driven command port (master 1). It sits between the project wrapper and the `keyvalue` core. It grants the slave to one master at a time using round-robin priority and holds the grant for the whole bus cycle (`cyc` high). A watchdog terminates stalled accesses with an error pulse.

---
 rtl/kv_arb_pkg.sv | 34 +++
 rtl/kv_arb_wdog.sv | 43 ++++
 rtl/kv_arbiter.sv | 191 +++++++++++++++++++
 tb/tb_kv_arbiter.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/kv_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : kv_arb_pkg
// Purpose  : Shared types and constants for the two-master keyvalue arbiter.
//            Arbiter state encoding, one-hot grant codes exported to the
//            logic analyzer, master-index type and a grant-code helper.
// Ports    : (package - no ports)
// Revision : 1.0 - initial release
// ============================================================================
package kv_arb_pkg;

   // Arbiter FSM states
   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } arb_state_t;

   // Master index: 0 = management SoC bus, 1 = logic-analyzer command port
   typedef logic mst_idx_t;

   localparam mst_idx_t MST_0 = 1'b0;
   localparam mst_idx_t MST_1 = 1'b1;

   // One-hot grant codes
   localparam logic [1:0] GRANT_NONE = 2'b00;
   localparam logic [1:0] GRANT_M0   = 2'b01;
   localparam logic [1:0] GRANT_M1   = 2'b10;

   function automatic logic [1:0] grant_of(input mst_idx_t idx);
      return (idx == MST_1) ? GRANT_M1 : GRANT_M0;
   endfunction

endpackage : kv_arb_pkg
`default_nettype wire

// File: rtl/kv_arb_wdog.sv
`default_nettype none
// ============================================================================
// Module   : kv_arb_wdog
// Purpose  : Stall watchdog for the arbiter. Counts cycles while enabled and
//            flags expiry once the count reaches TIMEOUT.
// Ports    : clk     in  1  rising-edge clock
//            rst     in  1  synchronous active-high reset
//            en      in  1  count this cycle
//            clr     in  1  clear the count (dominates en)
//            expired out 1  count equals TIMEOUT
// Revision : 1.0 - initial release
// ============================================================================
module kv_arb_wdog
   import kv_arb_pkg::*;
#(
   parameter int TIMEOUT = 15
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   input  logic clr,
   output logic expired
);

   localparam int              CW    = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0]   LIMIT = CW'(TIMEOUT);

   logic [CW-1:0] count;

   always_ff @(posedge clk) begin
      if (rst) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (en) begin
         count <= count + CW'(1);
      end
   end

   assign expired = (count == LIMIT);

endmodule : kv_arb_wdog
`default_nettype wire

// File: rtl/kv_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : kv_arbiter
// Purpose  : Two-master Wishbone arbiter sharing the keyvalue store between
//            the management-SoC bus (m0) and the LA command port (m1).
//            Round-robin on ties, grant held for the whole bus cycle, stall
//            watchdog terminating hung strobes with an error pulse.
// Ports    : sys_clk, sys_rst            clock / sync active-high reset
//            m0_cyc_i/stb_i/we_i/adr_i/dat_i   master 0 request
//            m0_ack_o/err_o/dat_o              master 0 response
//            m1_*                              same set for master 1
//            s_cyc_o/stb_o/we_o/adr_o/dat_o    request to keyvalue
//            s_ack_i/dat_i                     response from keyvalue
//            grant_o                           one-hot owner, 00 when idle
// Revision : 1.0 - initial release
// ============================================================================
module kv_arbiter
   import kv_arb_pkg::*;
#(
   parameter int DW      = 32,
   parameter int AW      = 32,
   parameter int TIMEOUT = 15
) (
   input  logic          sys_clk,
   input  logic          sys_rst,
   // master 0
   input  logic          m0_cyc_i,
   input  logic          m0_stb_i,
   input  logic          m0_we_i,
   input  logic [AW-1:0] m0_adr_i,
   input  logic [DW-1:0] m0_dat_i,
   output logic          m0_ack_o,
   output logic          m0_err_o,
   output logic [DW-1:0] m0_dat_o,
   // master 1
   input  logic          m1_cyc_i,
   input  logic          m1_stb_i,
   input  logic          m1_we_i,
   input  logic [AW-1:0] m1_adr_i,
   input  logic [DW-1:0] m1_dat_i,
   output logic          m1_ack_o,
   output logic          m1_err_o,
   output logic [DW-1:0] m1_dat_o,
   // slave
   output logic          s_cyc_o,
   output logic          s_stb_o,
   output logic          s_we_o,
   output logic [AW-1:0] s_adr_o,
   output logic [DW-1:0] s_dat_o,
   input  logic          s_ack_i,
   input  logic [DW-1:0] s_dat_i,
   // status
   output logic [1:0]    grant_o
);

   arb_state_t state, state_nxt;
   mst_idx_t   owner, owner_nxt;
   mst_idx_t   last,  last_nxt;

   logic          req0, req1, other_req;
   logic          busy;
   logic          own_cyc, own_stb, own_we;
   logic [AW-1:0] own_adr;
   logic [DW-1:0] own_dat;
   logic          wd_en, wd_clr, expired;

   assign req0 = m0_cyc_i & m0_stb_i;
   assign req1 = m1_cyc_i & m1_stb_i;

   // Reset gates the outputs combinationally so nothing leaks to either side
   // while reset is held, even if the registered state is still BUSY.
   assign busy = (state == ST_BUSY) & ~sys_rst;

   assign own_cyc   = (owner == MST_1) ? m1_cyc_i : m0_cyc_i;
   assign own_stb   = (owner == MST_1) ? m1_stb_i : m0_stb_i;
   assign own_we    = (owner == MST_1) ? m1_we_i  : m0_we_i;
   assign own_adr   = (owner == MST_1) ? m1_adr_i : m0_adr_i;
   assign own_dat   = (owner == MST_1) ? m1_dat_i : m0_dat_i;
   assign other_req = (owner == MST_1) ? req0     : req1;

   // ------------------------------------------------------------------------
   // Watchdog: counts stalled strobe cycles of the current owner. Any ack,
   // strobe gap, release or expiry restarts it so a new owner starts at 0.
   // ------------------------------------------------------------------------
   assign wd_en  = busy & own_cyc & own_stb & ~s_ack_i & ~expired;
   assign wd_clr = ~busy | ~own_cyc | ~own_stb | s_ack_i | expired;

   kv_arb_wdog #(
      .TIMEOUT (TIMEOUT)
   ) u_wdog (
      .clk     (sys_clk),
      .rst     (sys_rst),
      .en      (wd_en),
      .clr     (wd_clr),
      .expired (expired)
   );

   // ------------------------------------------------------------------------
   // FSM state register
   // ------------------------------------------------------------------------
   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         state <= ST_IDLE;
         owner <= MST_0;
         last  <= MST_1;   // m0 wins the first tie
      end else begin
         state <= state_nxt;
         owner <= owner_nxt;
         last  <= last_nxt;
      end
   end

   // ------------------------------------------------------------------------
   // FSM next-state logic
   // ------------------------------------------------------------------------
   always_comb begin
      state_nxt = state;
      owner_nxt = owner;
      last_nxt  = last;
      case (state)
         ST_IDLE: begin
            if (req0 | req1) begin
               state_nxt = ST_BUSY;
               if (req0 & req1) begin
                  owner_nxt = ~last;
               end else begin
                  owner_nxt = req1 ? MST_1 : MST_0;
               end
            end
         end
         ST_BUSY: begin
            if (expired) begin
               // Timed-out master goes to the back of the queue.
               last_nxt  = owner;
               state_nxt = ST_IDLE;
            end else if (!own_cyc) begin
               // With last = owner, the only eligible requester is the
               // other master, so handover is direct when it is waiting.
               last_nxt = owner;
               if (other_req) begin
                  owner_nxt = ~owner;
               end else begin
                  state_nxt = ST_IDLE;
               end
            end
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------------
   // Bus muxing. Each master's response depends only on registered owner
   // state and the slave response, never on the other master's inputs.
   // ------------------------------------------------------------------------
   always_comb begin
      s_cyc_o  = 1'b0;
      s_stb_o  = 1'b0;
      s_we_o   = 1'b0;
      s_adr_o  = '0;
      s_dat_o  = '0;
      m0_ack_o = 1'b0;
      m0_err_o = 1'b0;
      m0_dat_o = '0;
      m1_ack_o = 1'b0;
      m1_err_o = 1'b0;
      m1_dat_o = '0;
      grant_o  = GRANT_NONE;
      if (busy) begin
         // Expiry drops the slave request; a late ack is discarded.
         s_cyc_o = own_cyc & ~expired;
         s_stb_o = own_stb & ~expired;
         s_we_o  = own_we;
         s_adr_o = own_adr;
         s_dat_o = own_dat;
         grant_o = grant_of(owner);
         if (owner == MST_0) begin
            m0_ack_o = s_ack_i & ~expired;
            m0_err_o = expired;
            m0_dat_o = s_dat_i;
         end else begin
            m1_ack_o = s_ack_i & ~expired;
            m1_err_o = expired;
            m1_dat_o = s_dat_i;
         end
      end
   end

endmodule : kv_arbiter
`default_nettype wire

// File: tb/tb_kv_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_kv_arbiter
// Purpose  : Directed self-checking bench for kv_arbiter: single access,
//            round-robin ties, burst hold, watchdog expiry, reset mid-access
//            and ack coinciding with expiry.
// Revision : 1.0 - initial release
// ============================================================================
module tb_kv_arbiter;

   localparam int DW      = 32;
   localparam int AW      = 32;
   localparam int TIMEOUT = 15;

   logic          sys_clk = 1'b0;
   logic          sys_rst;
   logic          m0_cyc_i, m0_stb_i, m0_we_i;
   logic [AW-1:0] m0_adr_i;
   logic [DW-1:0] m0_dat_i;
   logic          m0_ack_o, m0_err_o;
   logic [DW-1:0] m0_dat_o;
   logic          m1_cyc_i, m1_stb_i, m1_we_i;
   logic [AW-1:0] m1_adr_i;
   logic [DW-1:0] m1_dat_i;
   logic          m1_ack_o, m1_err_o;
   logic [DW-1:0] m1_dat_o;
   logic          s_cyc_o, s_stb_o, s_we_o;
   logic [AW-1:0] s_adr_o;
   logic [DW-1:0] s_dat_o;
   logic          s_ack_i;
   logic [DW-1:0] s_dat_i;
   logic [1:0]    grant_o;

   int n_checks = 0;
   int n_fail   = 0;

   kv_arbiter #(
      .DW      (DW),
      .AW      (AW),
      .TIMEOUT (TIMEOUT)
   ) dut (
      .sys_clk  (sys_clk),
      .sys_rst  (sys_rst),
      .m0_cyc_i (m0_cyc_i),
      .m0_stb_i (m0_stb_i),
      .m0_we_i  (m0_we_i),
      .m0_adr_i (m0_adr_i),
      .m0_dat_i (m0_dat_i),
      .m0_ack_o (m0_ack_o),
      .m0_err_o (m0_err_o),
      .m0_dat_o (m0_dat_o),
      .m1_cyc_i (m1_cyc_i),
      .m1_stb_i (m1_stb_i),
      .m1_we_i  (m1_we_i),
      .m1_adr_i (m1_adr_i),
      .m1_dat_i (m1_dat_i),
      .m1_ack_o (m1_ack_o),
      .m1_err_o (m1_err_o),
      .m1_dat_o (m1_dat_o),
      .s_cyc_o  (s_cyc_o),
      .s_stb_o  (s_stb_o),
      .s_we_o   (s_we_o),
      .s_adr_o  (s_adr_o),
      .s_dat_o  (s_dat_o),
      .s_ack_i  (s_ack_i),
      .s_dat_i  (s_dat_i),
      .grant_o  (grant_o)
   );

   always #5 sys_clk = ~sys_clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Inputs change 1 time unit after the rising edge; checks follow 1 unit later.
   task automatic tick();
      @(posedge sys_clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic drv_m0(input logic cyc, input logic stb, input logic we,
                         input logic [AW-1:0] adr, input logic [DW-1:0] dat);
      m0_cyc_i = cyc; m0_stb_i = stb; m0_we_i = we; m0_adr_i = adr; m0_dat_i = dat;
   endtask

   task automatic drv_m1(input logic cyc, input logic stb, input logic we,
                         input logic [AW-1:0] adr, input logic [DW-1:0] dat);
      m1_cyc_i = cyc; m1_stb_i = stb; m1_we_i = we; m1_adr_i = adr; m1_dat_i = dat;
   endtask

   initial begin
      sys_rst = 1'b1;
      drv_m0(0, 0, 0, '0, '0);
      drv_m1(0, 0, 0, '0, '0);
      s_ack_i = 1'b0;
      s_dat_i = '0;
      tick();
      tick();

      // ---------------- reset: outputs held low ----------------
      drv_m0(1, 1, 1, 32'h10, 32'hA5);
      settle();
      chk("rst_grant", grant_o, 2'b00);
      chk("rst_scyc", s_cyc_o, 1'b0);
      tick();

      // ---------------- single master m0 write ----------------
      sys_rst = 1'b0;
      settle();
      chk("post_rst_sstb", s_stb_o, 1'b0);
      chk("post_rst_grant", grant_o, 2'b00);
      tick();                                   // cycle N+1
      chk("single_sstb", s_stb_o, 1'b1);
      chk("single_scyc", s_cyc_o, 1'b1);
      chk("single_swe", s_we_o, 1'b1);
      chk("single_sadr", s_adr_o, 32'h10);
      chk("single_sdat", s_dat_o, 32'hA5);
      chk("single_grant", grant_o, 2'b01);
      chk("single_noack", m0_ack_o, 1'b0);
      tick();
      chk("single_wait_ack", m0_ack_o, 1'b0);
      tick();
      s_ack_i = 1'b1;
      s_dat_i = 32'h1234;
      settle();
      chk("single_ack", m0_ack_o, 1'b1);
      chk("single_rdat", m0_dat_o, 32'h1234);
      chk("single_m1_ack", m1_ack_o, 1'b0);
      chk("single_m1_err", m1_err_o, 1'b0);
      chk("single_m1_dat", m1_dat_o, 32'h0);
      tick();
      drv_m0(0, 0, 0, 32'h10, 32'hA5);
      s_ack_i = 1'b0;
      settle();
      chk("single_rel_scyc", s_cyc_o, 1'b0);
      tick();
      chk("single_idle_grant", grant_o, 2'b00);

      // reset again so the next tie sees the reset round-robin pointer
      sys_rst = 1'b1;
      tick();
      sys_rst = 1'b0;

      // ---------------- tie after reset ----------------
      drv_m0(1, 1, 0, 32'h20, 32'h0);
      drv_m1(1, 1, 0, 32'h30, 32'h0);
      tick();
      chk("tie1_grant", grant_o, 2'b01);
      chk("tie1_sadr", s_adr_o, 32'h20);
      s_ack_i = 1'b1;
      settle();
      chk("tie1_m0_ack", m0_ack_o, 1'b1);
      chk("tie1_m1_ack", m1_ack_o, 1'b0);
      tick();
      drv_m0(0, 0, 0, 32'h20, 32'h0);
      s_ack_i = 1'b0;
      settle();
      chk("tie1_rel_grant", grant_o, 2'b01);
      tick();                                   // handover with no idle cycle
      chk("handover_grant", grant_o, 2'b10);
      chk("handover_scyc", s_cyc_o, 1'b1);
      chk("handover_sadr", s_adr_o, 32'h30);
      s_ack_i = 1'b1;
      settle();
      chk("handover_m1_ack", m1_ack_o, 1'b1);
      chk("handover_m0_ack", m0_ack_o, 1'b0);
      tick();
      drv_m1(0, 0, 0, 32'h30, 32'h0);
      s_ack_i = 1'b0;
      tick();
      chk("tie1_idle", grant_o, 2'b00);
      drv_m0(1, 1, 0, 32'h20, 32'h0);
      drv_m1(1, 1, 0, 32'h30, 32'h0);
      tick();
      chk("tie2_grant", grant_o, 2'b01);
      drv_m0(0, 0, 0, 32'h20, 32'h0);
      drv_m1(0, 0, 0, 32'h30, 32'h0);
      tick();
      tick();
      chk("tie2_idle", grant_o, 2'b00);

      // ---------------- burst hold (m1 four strobes) ----------------
      drv_m1(1, 1, 1, 32'h40, 32'h0);
      tick();
      chk("burst_grant", grant_o, 2'b10);
      drv_m0(1, 1, 0, 32'h50, 32'h0);
      for (int i = 0; i < 4; i++) begin
         drv_m1(1, 1, 1, 32'h40 + i, 32'h100 + i);
         s_ack_i = 1'b1;
         settle();
         chk("burst_m1_ack", m1_ack_o, 1'b1);
         chk("burst_m0_ack", m0_ack_o, 1'b0);
         chk("burst_sadr", s_adr_o, 32'h40 + i);
         tick();
         drv_m1(1, 0, 1, 32'h40 + i, 32'h100 + i);
         s_ack_i = 1'b0;
         settle();
         chk("burst_gap_grant", grant_o, 2'b10);
         chk("burst_gap_sstb", s_stb_o, 1'b0);
         tick();
      end
      drv_m1(0, 0, 0, 32'h0, 32'h0);
      settle();
      chk("burst_rel_grant", grant_o, 2'b10);
      tick();
      chk("burst_m0_grant", grant_o, 2'b01);
      chk("burst_m0_sadr", s_adr_o, 32'h50);
      drv_m0(0, 0, 0, 32'h50, 32'h0);
      tick();
      chk("burst_idle", grant_o, 2'b00);

      // ---------------- watchdog expiry ----------------
      drv_m0(1, 1, 0, 32'h60, 32'h0);
      tick();                                   // first granted strobe cycle
      drv_m1(1, 1, 0, 32'h70, 32'h0);
      for (int i = 0; i < TIMEOUT; i++) begin
         settle();
         chk("wd_pre_err", m0_err_o, 1'b0);
         tick();
      end
      settle();
      chk("wd_err", m0_err_o, 1'b1);
      chk("wd_ack", m0_ack_o, 1'b0);
      chk("wd_scyc", s_cyc_o, 1'b0);
      chk("wd_sstb", s_stb_o, 1'b0);
      chk("wd_m1_err", m1_err_o, 1'b0);
      tick();
      chk("wd_err_pulse", m0_err_o, 1'b0);
      chk("wd_idle", grant_o, 2'b00);
      tick();
      chk("wd_m1_next", grant_o, 2'b10);
      chk("wd_m1_sadr", s_adr_o, 32'h70);

      // ---------------- reset mid-access (m1 owner) ----------------
      sys_rst = 1'b1;
      s_ack_i = 1'b1;
      settle();
      chk("midrst_hold_grant", grant_o, 2'b00);
      chk("midrst_hold_m1_ack", m1_ack_o, 1'b0);
      tick();
      sys_rst = 1'b0;
      settle();
      chk("midrst_grant", grant_o, 2'b00);
      chk("midrst_scyc", s_cyc_o, 1'b0);
      chk("midrst_m1_ack", m1_ack_o, 1'b0);
      chk("midrst_m1_err", m1_err_o, 1'b0);
      chk("midrst_m0_ack", m0_ack_o, 1'b0);
      tick();
      chk("midrst_tie_m0", grant_o, 2'b01);

      // ---------------- ack coincides with expiry ----------------
      s_ack_i = 1'b0;
      drv_m1(0, 0, 0, 32'h70, 32'h0);
      for (int i = 0; i < TIMEOUT; i++) begin
         settle();
         chk("late_pre_err", m0_err_o, 1'b0);
         tick();
      end
      s_ack_i = 1'b1;
      settle();
      chk("late_err", m0_err_o, 1'b1);
      chk("late_ack", m0_ack_o, 1'b0);
      chk("late_sstb", s_stb_o, 1'b0);
      tick();
      s_ack_i = 1'b0;
      drv_m0(0, 0, 0, 32'h0, 32'h0);
      settle();
      chk("late_idle_grant", grant_o, 2'b00);
      chk("late_idle_err", m0_err_o, 1'b0);
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule : tb_kv_arbiter
`default_nettype wire
